// File: rtl/acorn128_init.sv
// acorn128_init: ACORN-128 initialization stage. It loads the key and IV into a zeroed
//   293-bit state and runs the 1792 state-update steps with ca=cb=1.
// Latency: start sampled at edge E0; final state registered at edge E(INIT_STEPS/UNROLL);
//   done is high for the cycle after that edge.
// Backpressure: none. start is ignored while busy, and is accepted in IDLE or DONE.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   start        begin initialization (1-cycle pulse sufficient)
//   key, iv      128-bit key / IV, latched when start is accepted; bit 0 is consumed first
//   busy         high while steps are running
//   done         1-cycle pulse when the final state is ready
//   state_valid  state_out holds a completed initialization (held until next start/rst)
//   state_out    ACORN state, bit j = S_j
module acorn128_init #(
    parameter int UNROLL     = 1,    // steps per clock: 1, 2, 4, 8, 16 or 32
    parameter int INIT_STEPS = 1792  // fixed by the algorithm
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    output logic         busy,
    output logic         done,
    output logic         state_valid,
    output logic [292:0] state_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam logic [10:0] LP_UNROLL = 11'(UNROLL);
    localparam logic [10:0] LP_STEPS  = 11'(INIT_STEPS);

    fsm_t           r_fsm;
    fsm_t           w_fsm_nxt;
    logic [10:0]    r_cnt;
    logic [127:0]   r_key;
    logic [127:0]   r_iv;
    logic [292:0]   r_state;
    logic           r_state_valid;
    logic           w_accept;
    logic [292:0]   w_step_state;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Message bit for step i. Steps past 255 reuse the key with i mod 128,
    // except step 256 which injects the inverted first key bit.
    function automatic logic msg_bit(input logic [10:0] i,
                                     input logic [127:0] k,
                                     input logic [127:0] v);
        logic m;
        if (i < 11'd128)
            m = k[i[6:0]];
        else if (i < 11'd256)
            m = v[i[6:0]];
        else if (i == 11'd256)
            m = ~k[0];
        else
            m = k[i[6:0]];
        return m;
    endfunction

    // One ACORN state update with ca=cb=1. The six LFSR feedbacks are applied
    // in order, each seeing the previously updated bits.
    function automatic logic [292:0] acorn_step(input logic [292:0] s_in, input logic m);
        logic [292:0] s;
        logic         ks;
        logic         f;
        s      = s_in;
        s[288] = s[288] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        ks     = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
        f      = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ s[196] ^ ks;
        return {f ^ m, s[292:1]};
    endfunction

    // UNROLL steps chained combinationally; step indices r_cnt .. r_cnt+UNROLL-1.
    always_comb begin
        w_step_state = r_state;
        for (int k = 0; k < UNROLL; k++) begin
            w_step_state = acorn_step(w_step_state, msg_bit(r_cnt + 11'(k), r_key, r_iv));
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_accept  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_fsm_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt + LP_UNROLL == LP_STEPS)
                    w_fsm_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                // Accepting start here allows back-to-back runs with no idle gap.
                if (start) begin
                    w_accept  = 1'b1;
                    w_fsm_nxt = ST_RUN;
                end else begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm         <= ST_IDLE;
            r_cnt         <= '0;
            r_key         <= '0;
            r_iv          <= '0;
            r_state       <= '0;
            r_state_valid <= 1'b0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_accept) begin
                r_key         <= key;
                r_iv          <= iv;
                r_state       <= '0;
                r_cnt         <= '0;
                r_state_valid <= 1'b0;
            end else if (r_fsm == ST_RUN) begin
                r_state <= w_step_state;
                r_cnt   <= r_cnt + LP_UNROLL;
                if (w_fsm_nxt == ST_DONE)
                    r_state_valid <= 1'b1;
            end
        end
    end

    assign state_valid = r_state_valid;
    assign state_out   = r_state;

endmodule

// File: tb/tb_acorn128_init.sv
module tb_acorn128_init;

    logic         clk;
    logic         rst;
    logic         start, start8;
    logic [127:0] key, iv, key8, iv8;
    logic         busy, done, state_valid;
    logic         busy8, done8, state_valid8;
    logic [292:0] state_out, state_out8;

    int n_checks = 0;
    int n_pass   = 0;

    acorn128_init #(.UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
        .busy(busy), .done(done), .state_valid(state_valid), .state_out(state_out)
    );

    acorn128_init #(.UNROLL(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .key(key8), .iv(iv8),
        .busy(busy8), .done(done8), .state_valid(state_valid8), .state_out(state_out8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic bit ref_maj(input bit x, input bit y, input bit z);
        int votes;
        votes = int'(x) + int'(y) + int'(z);
        return votes >= 2;
    endfunction

    function automatic bit ref_ch(input bit x, input bit y, input bit z);
        return x ? y : z;
    endfunction

    // The state is a queue with S_0 at the front: each step drops S_0 and
    // appends the new S_292 at the back.
    function automatic logic [292:0] ref_init(input logic [127:0] k, input logic [127:0] v);
        bit s[$];
        bit m, ks, f;
        logic [292:0] r;
        for (int j = 0; j < 293; j++) s.push_back(1'b0);
        for (int i = 0; i < 1792; i++) begin
            if (i < 128)       m = k[i];
            else if (i < 256)  m = v[i - 128];
            else if (i == 256) m = !k[0];
            else               m = k[i % 128];
            s[288] = s[288] ^ s[235] ^ s[230];
            s[230] = s[230] ^ s[196] ^ s[193];
            s[193] = s[193] ^ s[160] ^ s[154];
            s[154] = s[154] ^ s[111] ^ s[107];
            s[107] = s[107] ^ s[66]  ^ s[61];
            s[61]  = s[61]  ^ s[23]  ^ s[0];
            ks = s[12] ^ s[154] ^ ref_maj(s[235], s[61], s[193]) ^ ref_ch(s[230], s[111], s[66]);
            f  = s[0] ^ !s[107] ^ ref_maj(s[244], s[23], s[160]) ^ s[196] ^ ks;
            void'(s.pop_front());
            s.push_back(f ^ m);
        end
        for (int j = 0; j < 293; j++) r[j] = s[j];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic pulse_start(input logic [127:0] k, input logic [127:0] v);
        @(negedge clk);
        key = k; iv = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge following the accepting edge E0. Returns the
    // negedge index (0 = just after E0) at which done is seen, and the number
    // of negedges with busy high before that.
    task automatic wait_done(output int busy_cnt, output int n);
        busy_cnt = 0;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start8 = 1'b0;
        key = '0; iv = '0; key8 = '0; iv8 = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (state_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", state_valid); else n_pass++;
        n_checks++; if (state_out !== '0) $display("FAIL reset_state got=%h exp=0", state_out); else n_pass++;
        n_checks++; if (state_out8 !== '0 || busy8 !== 1'b0) $display("FAIL reset_dut8 busy=%b state=%h exp=0", busy8, state_out8); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset busy=%b done=%b exp=0,0", busy, done); else n_pass++;
    endtask

    task automatic test_kat_zero();
        logic [292:0] exp_st;
        int bc, n, extra;
        exp_st = ref_init('0, '0);
        pulse_start('0, '0);
        wait_done(bc, n);
        n_checks++; if (bc !== 1792) $display("FAIL kat0_busy_cycles got=%0d exp=1792", bc); else n_pass++;
        n_checks++; if (n !== 1792) $display("FAIL kat0_done_cycle got=%0d exp=1792", n); else n_pass++;
        n_checks++; if (state_out !== exp_st) $display("FAIL kat0_state got=%h exp=%h", state_out, exp_st); else n_pass++;
        n_checks++; if (state_valid !== 1'b1) $display("FAIL kat0_valid got=%b exp=1", state_valid); else n_pass++;
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL kat0_single_done extra_pulses=%0d exp=0", extra); else n_pass++;
        n_checks++; if (state_valid !== 1'b1 || busy !== 1'b0) $display("FAIL kat0_hold_valid valid=%b busy=%b exp=1,0", state_valid, busy); else n_pass++;
        n_checks++; if (state_out !== exp_st) $display("FAIL kat0_hold_state got=%h exp=%h", state_out, exp_st); else n_pass++;
    endtask

    task automatic test_indexing();
        logic [127:0] k, v;
        logic [292:0] exp_st;
        int bc, n;
        k = 128'h1;
        v = 128'h1 << 127;
        exp_st = ref_init(k, v);
        pulse_start(k, v);
        wait_done(bc, n);
        n_checks++; if (n !== 1792) $display("FAIL index_done_cycle got=%0d exp=1792", n); else n_pass++;
        n_checks++; if (state_out !== exp_st) $display("FAIL index_state got=%h exp=%h", state_out, exp_st); else n_pass++;
    endtask

    task automatic test_isolation();
        logic [127:0] k, v;
        logic [292:0] exp_st;
        int n;
        k = rand128();
        v = rand128();
        exp_st = ref_init(k, v);
        pulse_start(k, v);
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            if (n == 10 || n == 1000) begin
                key = rand128(); iv = rand128(); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        n_checks++; if (n !== 1792) $display("FAIL isolate_done_cycle got=%0d exp=1792", n); else n_pass++;
        n_checks++; if (state_out !== exp_st) $display("FAIL isolate_state got=%h exp=%h", state_out, exp_st); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic [127:0] k, v;
        logic [292:0] exp_st;
        int bc, n, dones;
        pulse_start(rand128(), rand128());
        dones = 0;
        for (int c = 0; c < 900; c++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0 || dones !== 0) $display("FAIL midrst_done got=%b early_pulses=%0d exp=0", done, dones); else n_pass++;
        n_checks++; if (state_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", state_valid); else n_pass++;
        n_checks++; if (state_out !== '0) $display("FAIL midrst_state got=%h exp=0", state_out); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        k = rand128();
        v = rand128();
        exp_st = ref_init(k, v);
        pulse_start(k, v);
        wait_done(bc, n);
        n_checks++; if (n !== 1792 || bc !== 1792) $display("FAIL midrst_rerun_cycles done=%0d busy=%0d exp=1792", n, bc); else n_pass++;
        n_checks++; if (state_out !== exp_st) $display("FAIL midrst_rerun_state got=%h exp=%h", state_out, exp_st); else n_pass++;
    endtask

    task automatic test_unroll8();
        logic [127:0] k, v;
        logic [292:0] exp_st, st8;
        int n, n8;
        k = rand128();
        v = rand128();
        exp_st = ref_init(k, v);
        @(negedge clk);
        key = k; iv = v; key8 = k; iv8 = v;
        start = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        n = 0;
        n8 = -1;
        st8 = '0;
        while (done !== 1'b1 && n < 4000) begin
            if (done8 === 1'b1 && n8 < 0) begin
                n8 = n;
                st8 = state_out8;
            end
            @(negedge clk);
            n++;
        end
        n_checks++; if (n8 !== 224) $display("FAIL unroll8_done_cycle got=%0d exp=224", n8); else n_pass++;
        n_checks++; if (st8 !== exp_st) $display("FAIL unroll8_state got=%h exp=%h", st8, exp_st); else n_pass++;
        n_checks++; if (state_valid8 !== 1'b1) $display("FAIL unroll8_valid got=%b exp=1", state_valid8); else n_pass++;
        n_checks++; if (n !== 1792 || state_out !== state_out8) $display("FAIL unroll8_vs_unroll1 done1=%0d s1=%h s8=%h", n, state_out, state_out8); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1, v1, k2, v2;
        logic [292:0] exp1, exp2;
        int bc, n;
        k1 = rand128(); v1 = rand128();
        k2 = rand128(); v2 = rand128();
        exp1 = ref_init(k1, v1);
        exp2 = ref_init(k2, v2);
        pulse_start(k1, v1);
        wait_done(bc, n);
        n_checks++; if (n !== 1792) $display("FAIL b2b_first_done got=%0d exp=1792", n); else n_pass++;
        n_checks++; if (state_out !== exp1) $display("FAIL b2b_first_state got=%h exp=%h", state_out, exp1); else n_pass++;
        // Still in the DONE cycle: request the second run now.
        key = k2; iv = v2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (state_valid !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_restart valid=%b busy=%b exp=0,1", state_valid, busy); else n_pass++;
        wait_done(bc, n);
        n_checks++; if (n !== 1792) $display("FAIL b2b_second_done got=%0d exp=1792", n); else n_pass++;
        n_checks++; if (state_out !== exp2) $display("FAIL b2b_second_state got=%h exp=%h", state_out, exp2); else n_pass++;
        n_checks++; if (state_valid !== 1'b1) $display("FAIL b2b_second_valid got=%b exp=1", state_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_kat_zero();
        test_indexing();
        test_isolation();
        test_reset_midrun();
        test_unroll8();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
